control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Clk  input  1  rising-edge system clock.
REQ-003 Rst_n  input  1  synchronous active-low reset, sampled on the Clk rising edge.
REQ-004 Instr_id  input  5  decoded instruction id:
  - 0 NULL; 1-9 R-type (ADD..SLT); 10-16 I-type (ADDI..SRAI); 17 LW; 18 SW; 19 JAL.
  - 20-31 SHALL be treated as NULL.
REQ-005 Mem_ready  input  1  memory handshake; the current access completes in any cycle with Mem_req=1 and Mem_ready=1.
REQ-006 Mem_req  output  1  memory access request.
REQ-007 Mem_we  output  1  write qualifier; valid only while Mem_req=1.
REQ-008 Mem_addr_sel  output  1  memory address source: 0=PC, 1=ALU result.
REQ-009 Instr_we  output  1  instruction-register load strobe.
REQ-010 Pc_we  output  1  PC load strobe.
REQ-011 Pc_sel  output  1  next-PC source: 0=PC+4, 1=JAL target.
REQ-012 Alu_src_b  output  1  ALU operand B source: 0=rs2, 1=immediate.
REQ-013 Reg_we  output  1  register-file write strobe.
REQ-014 Wb_sel  output  2  write-back source: 0=ALU, 1=memory data, 2=PC+4; 3 is unused.
REQ-015 Halted  output  1  core stopped after an illegal instruction.
REQ-016 State  output  4  current state code, for debug.

Function
REQ-017 Output timing:
  - Outputs SHALL be decoded combinationally from the state register.
  - Instr_we and Pc_we MAY additionally depend on Mem_ready.
  - No output SHALL depend on Instr_id except through the state.
REQ-018 States and codes: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, WB_ALU=4, MEM_RD=5, WB_MEM=6, MEM_WR=7, WB_JAL=8, HALT=9.
REQ-019 FETCH:
  - Outputs: Mem_req=1, Mem_we=0, Mem_addr_sel=0.
  - If Mem_ready=1: Instr_we=1 in the same cycle, next state DECODE.
  - Otherwise: stay in FETCH.
REQ-020 DECODE SHALL last exactly one cycle with all strobes 0; next state by Instr_id:
  - R-type -> EXEC_R
  - I-type, LW, SW -> EXEC_I
  - JAL -> WB_JAL
  - NULL -> per REQ-031
REQ-021 EXEC_R SHALL drive Alu_src_b=0 for one cycle, then go to WB_ALU.
REQ-022 EXEC_I SHALL drive Alu_src_b=1 for one cycle, then go to:
  - LW -> MEM_RD
  - SW -> MEM_WR
  - otherwise -> WB_ALU
REQ-023 The Instr_id used in EXEC_I SHALL be the value registered in DECODE.
REQ-024 WB_ALU SHALL drive Reg_we=1, Wb_sel=0, Pc_we=1, Pc_sel=0 for one cycle, then go to FETCH.
REQ-025 MEM_RD:
  - Outputs: Mem_req=1, Mem_we=0, Mem_addr_sel=1, Alu_src_b=1.
  - Holds until Mem_ready=1, then goes to WB_MEM.
REQ-026 WB_MEM SHALL drive Reg_we=1, Wb_sel=1, Pc_we=1, Pc_sel=0 for one cycle, then go to FETCH.
REQ-027 MEM_WR:
  - Outputs: Mem_req=1, Mem_we=1, Mem_addr_sel=1, Alu_src_b=1.
  - On Mem_ready=1: Pc_we=1, Pc_sel=0 in that cycle, next state FETCH.
REQ-028 WB_JAL SHALL drive Reg_we=1, Wb_sel=2, Pc_we=1, Pc_sel=1 for one cycle, then go to FETCH.
REQ-029 Latency with Mem_ready tied high, counted from FETCH entry to the next FETCH entry:
  - R/I: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - JAL: 3 cycles
REQ-030 Mem_req handshake:
  - Once asserted, Mem_req SHALL remain high with Mem_we and Mem_addr_sel stable until the completing cycle.
  - Each Mem_ready wait SHALL be unbounded, with no timeout.
  - Mem_ready while Mem_req=0 SHALL be ignored.
REQ-031 Outside its 0-9 state list, State SHALL never show a code in 10-15; any such code reached SHALL recover to FETCH on the next edge.

Reset
REQ-032 While Rst_n=0 at a Clk edge, the state register SHALL load FETCH, regardless of current state, including mid-handshake.
REQ-033 While Rst_n=0, all outputs SHALL be forced to 0, including Mem_req, Halted and State.
REQ-034 The first request SHALL appear in the first cycle after Rst_n samples high.

Configuration
REQ-035 The macro ILLEGAL_TRAP_EN SHALL select NULL-instruction handling.
REQ-036 With ILLEGAL_TRAP_EN defined:
  - DECODE with NULL -> HALT.
  - HALT: all strobes 0, Halted=1, held until reset.
REQ-037 With ILLEGAL_TRAP_EN undefined:
  - DECODE with NULL -> WB_ALU with Reg_we forced 0 (NOP, PC+4).
  - HALT is unreachable and Halted is tied 0.

Verification
REQ-038 Reset then Mem_ready=1, Instr_id=1 (ADD):
  - States 0,1,2,4,0.
  - Reg_we=1, Wb_sel=0, Pc_we=1 only in state 4.
REQ-039 Instr_id=17 (LW), Mem_ready low 3 cycles in MEM_RD:
  - MEM_RD held 4 cycles, Mem_req stable.
  - Then WB_MEM with Wb_sel=1.
REQ-040 Instr_id=18 (SW):
  - MEM_WR shows Mem_we=1, Mem_addr_sel=1.
  - Pc_we=1 in the ready cycle; Reg_we never 1.
REQ-041 Instr_id=19 (JAL): WB_JAL shows Pc_sel=1, Wb_sel=2, Reg_we=1; total 3 cycles.
REQ-042 Instr_id=0 and Instr_id=25:
  - With macro: Halted=1 persists 10 cycles.
  - Without macro: returns to FETCH with Reg_we=0, Pc_we=1.
REQ-043 Rst_n low for one edge during MEM_RD with Mem_ready=0:
  - Next state FETCH; outputs 0 during reset.
  - Fetch resumes after reset release.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/write-back sequencing with a memory handshake.
// Build option ILLEGAL_TRAP_EN: NULL instructions halt the core instead of executing as a NOP.
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] instr_id,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       instr_we,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       alu_src_b,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       halted,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    WB_ALU = 4'd4,
    MEM_RD = 4'd5,
    WB_MEM = 4'd6,
    MEM_WR = 4'd7,
    WB_JAL = 4'd8,
    HALT   = 4'd9
  } state_t;

  localparam logic [4:0] ID_LW  = 5'd17;
  localparam logic [4:0] ID_SW  = 5'd18;
  localparam logic [4:0] ID_JAL = 5'd19;

  state_t     state_reg, state_next;
  logic [4:0] instr_reg;
  logic       nop_reg, nop_next;

  logic       id_r, id_i, id_mem;
  logic       mem_req_dec, mem_we_dec, mem_addr_sel_dec, instr_we_dec;
  logic       pc_we_dec, pc_sel_dec, alu_src_b_dec, reg_we_dec, halted_dec;
  logic [1:0] wb_sel_dec;
  logic [3:0] state_dec;

  assign id_r   = (instr_id >= 5'd1)  && (instr_id <= 5'd9);
  assign id_i   = (instr_id >= 5'd10) && (instr_id <= 5'd16);
  assign id_mem = (instr_id == ID_LW) || (instr_id == ID_SW);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= FETCH;
      instr_reg <= 5'd0;
      nop_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      nop_reg   <= nop_next;
      // Captured in DECODE so EXEC_I branches on the instruction actually decoded.
      if (state_reg == DECODE)
        instr_reg <= instr_id;
    end
  end

  always_comb begin
    state_next       = state_reg;
    nop_next         = 1'b0;
    mem_req_dec      = 1'b0;
    mem_we_dec       = 1'b0;
    mem_addr_sel_dec = 1'b0;
    instr_we_dec     = 1'b0;
    pc_we_dec        = 1'b0;
    pc_sel_dec       = 1'b0;
    alu_src_b_dec    = 1'b0;
    reg_we_dec       = 1'b0;
    wb_sel_dec       = 2'd0;
    halted_dec       = 1'b0;
    state_dec        = state_reg;
    case (state_reg)
      FETCH: begin
        mem_req_dec = 1'b1;
        if (mem_ready) begin
          instr_we_dec = 1'b1;
          state_next   = DECODE;
        end
      end
      DECODE: begin
        if (id_r)
          state_next = EXEC_R;
        else if (id_i || id_mem)
          state_next = EXEC_I;
        else if (instr_id == ID_JAL)
          state_next = WB_JAL;
        else begin
`ifdef ILLEGAL_TRAP_EN
          state_next = HALT;
`else
          state_next = WB_ALU;
          nop_next   = 1'b1;
`endif
        end
      end
      EXEC_R: state_next = WB_ALU;
      EXEC_I: begin
        alu_src_b_dec = 1'b1;
        if (instr_reg == ID_LW)
          state_next = MEM_RD;
        else if (instr_reg == ID_SW)
          state_next = MEM_WR;
        else
          state_next = WB_ALU;
      end
      WB_ALU: begin
        // A NULL instruction passes through here as a NOP: PC advances, no register write.
        reg_we_dec = ~nop_reg;
        pc_we_dec  = 1'b1;
        state_next = FETCH;
      end
      MEM_RD: begin
        mem_req_dec      = 1'b1;
        mem_addr_sel_dec = 1'b1;
        alu_src_b_dec    = 1'b1;
        if (mem_ready)
          state_next = WB_MEM;
      end
      WB_MEM: begin
        reg_we_dec = 1'b1;
        wb_sel_dec = 2'd1;
        pc_we_dec  = 1'b1;
        state_next = FETCH;
      end
      MEM_WR: begin
        mem_req_dec      = 1'b1;
        mem_we_dec       = 1'b1;
        mem_addr_sel_dec = 1'b1;
        alu_src_b_dec    = 1'b1;
        if (mem_ready) begin
          pc_we_dec  = 1'b1;
          state_next = FETCH;
        end
      end
      WB_JAL: begin
        reg_we_dec = 1'b1;
        wb_sel_dec = 2'd2;
        pc_we_dec  = 1'b1;
        pc_sel_dec = 1'b1;
        state_next = FETCH;
      end
      HALT: begin
`ifdef ILLEGAL_TRAP_EN
        halted_dec = 1'b1;
`else
        state_next = FETCH;
`endif
      end
      default: begin
        // Unused codes never reach the debug port and fall back to FETCH.
        state_next = FETCH;
        state_dec  = FETCH;
      end
    endcase
  end

  assign mem_req      = rst_n & mem_req_dec;
  assign mem_we       = rst_n & mem_we_dec;
  assign mem_addr_sel = rst_n & mem_addr_sel_dec;
  assign instr_we     = rst_n & instr_we_dec;
  assign pc_we        = rst_n & pc_we_dec;
  assign pc_sel       = rst_n & pc_sel_dec;
  assign alu_src_b    = rst_n & alu_src_b_dec;
  assign reg_we       = rst_n & reg_we_dec;
  assign wb_sel       = rst_n ? wb_sel_dec : 2'd0;
  assign halted       = rst_n & halted_dec;
  assign state        = rst_n ? state_dec : 4'd0;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle expected output vectors queued with the stimulus.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] instr_id;
  logic       mem_ready;
  logic       mem_req, mem_we, mem_addr_sel, instr_we, pc_we, pc_sel, alu_src_b, reg_we, halted;
  logic [1:0] wb_sel;
  logic [3:0] state;

  typedef struct packed {
    logic       rn;
    logic [4:0] id;
    logic       mr;
  } stim_t;

  stim_t       stim_q[$];
  logic [14:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .instr_id(instr_id), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .instr_we(instr_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .alu_src_b(alu_src_b), .reg_we(reg_we),
    .wb_sel(wb_sel), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  // {state, req, we, addr_sel, instr_we, pc_we, pc_sel, alu_src_b, reg_we, wb_sel, halted}
  function automatic logic [14:0] ev(input int st, input bit req, input bit we, input bit asel,
                                     input bit iwe, input bit pwe, input bit psel, input bit asb,
                                     input bit rwe, input int wsel, input bit hlt);
    return {st[3:0], req, we, asel, iwe, pwe, psel, asb, rwe, wsel[1:0], hlt};
  endfunction

  task automatic push(input bit rn, input int id, input bit mr, input logic [14:0] e);
    stim_t s;
    s.rn = rn;
    s.id = id[4:0];
    s.mr = mr;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Drive one cycle, sample mid-cycle, then advance past the next rising edge.
  task automatic drive_cycle(input stim_t s, output logic [14:0] o);
    rst_n     = s.rn;
    instr_id  = s.id;
    mem_ready = s.mr;
    #1;
    o = {state, mem_req, mem_we, mem_addr_sel, instr_we, pc_we, pc_sel, alu_src_b, reg_we, wb_sel, halted};
    @(posedge clk);
    #1;
  endtask

  // Expected sequence for one instruction with memory always ready.
  task automatic push_instr(input int id);
    push(1, id, 1, ev(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    push(1, id, 1, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (id <= 9) begin
      push(1, id, 1, ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      push(1, id, 1, ev(4, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    end else if (id <= 16) begin
      push(1, id, 1, ev(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      push(1, id, 1, ev(4, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    end else if (id == 17) begin
      push(1, id, 1, ev(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      push(1, id, 1, ev(5, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0));
      push(1, id, 1, ev(6, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
    end else if (id == 18) begin
      push(1, id, 1, ev(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      push(1, id, 1, ev(7, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0));
    end else begin
      push(1, id, 1, ev(8, 0, 0, 0, 0, 1, 1, 0, 1, 2, 0));
    end
  endtask

  task automatic test_reset;
    logic [14:0] o, e;
    stim_t s;
    int n = 0;
    push(0, 1, 1, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(0, 1, 1, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(1, 1, 0, ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive_cycle(s, o);
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset cyc%0d: got=%h need=%h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_add;
    logic [14:0] o, e;
    stim_t s;
    int n = 0;
    push(1, 1, 0, ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(1, 1, 1, ev(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    push(1, 1, 1, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(1, 1, 1, ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(1, 1, 1, ev(4, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    push(1, 1, 0, ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive_cycle(s, o);
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL add cyc%0d: got=%h need=%h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_lw_wait;
    logic [14:0] o, e;
    stim_t s;
    int n = 0;
    push(1, 17, 1, ev(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    push(1, 17, 1, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(1, 5,  1, ev(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      push(1, 18, 0, ev(5, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    push(1, 18, 1, ev(5, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    push(1, 18, 1, ev(6, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive_cycle(s, o);
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL lw_wait cyc%0d: got=%h need=%h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_sw;
    logic [14:0] o, e;
    stim_t s;
    int n = 0;
    push(1, 18, 1, ev(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    push(1, 18, 1, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(1, 0,  1, ev(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    push(1, 17, 0, ev(7, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    push(1, 17, 1, ev(7, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0));
    push(1, 17, 0, ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive_cycle(s, o);
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL sw cyc%0d: got=%h need=%h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_jal;
    logic [14:0] o, e;
    stim_t s;
    int n = 0;
    push_instr(19);
    push(1, 19, 0, ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive_cycle(s, o);
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL jal cyc%0d: got=%h need=%h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_null;
    logic [14:0] o, e;
    stim_t s;
    int n = 0;
    int ids[2] = '{0, 25};
    foreach (ids[k]) begin
      push(1, ids[k], 1, ev(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      push(1, ids[k], 1, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 10; i++)
        push(1, 1, 1, ev(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      push(0, 1, 1, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`else
      push(1, ids[k], 1, ev(4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
`endif
    end
    push(1, 0, 0, ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive_cycle(s, o);
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL null cyc%0d: got=%h need=%h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid;
    logic [14:0] o, e;
    stim_t s;
    int n = 0;
    push(1, 17, 1, ev(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    push(1, 17, 1, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(1, 17, 1, ev(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    push(1, 17, 0, ev(5, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    push(0, 17, 0, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(1, 1,  1, ev(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    push(1, 1,  1, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(1, 1,  1, ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(1, 1,  1, ev(4, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive_cycle(s, o);
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset_mid cyc%0d: got=%h need=%h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_back_to_back;
    logic [14:0] o, e;
    stim_t s;
    int n = 0;
    int seq[8] = '{19, 17, 18, 3, 12, 0, 0, 0};
    for (int i = 5; i < 8; i++)
      seq[i] = int'($urandom_range(1, 19));
    foreach (seq[k])
      push_instr(seq[k]);
    push(1, 0, 0, ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive_cycle(s, o);
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL back_to_back cyc%0d id=%0d: got=%h need=%h", n, s.id, o, e);
      end
      n++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    instr_id  = 5'd0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset;
    test_add;
    test_lw_wait;
    test_sw;
    test_jal;
    test_null;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
